// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target at a single 7-bit bus address.
// A write transaction sets an 8-bit register pointer, then presents each
// following byte on the user register port. A read transaction streams bytes
// fetched from that port. scl is only sampled; sda is open-drain.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h77,
    parameter logic [7:0] PTR_RESET  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        IGNORE    = 4'd9
    } state_t;

    // Input synchronizers and edge-detect delay flops
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Bus events derived from the synchronized lines
    logic scl_rise, scl_fall;
    logic start_cond, stop_cond;
    logic [7:0] shift_in;

    // Registered FSM state and datapath
    state_t     cur_state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rw;
    logic       drive_low;

    // Next-state values computed combinationally
    state_t     nxt_state;
    logic [2:0] nxt_bit_cnt;
    logic [7:0] nxt_shift;
    logic       nxt_rw;
    logic       nxt_drive_low;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_wdata;
    logic       nxt_we;
    logic       nxt_busy;

    assign sda   = drive_low ? 1'b0 : 1'bz;
    assign state = cur_state;

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign shift_in   = {shift_reg[6:0], sda_s2};

    // Two-flop synchronizers plus a delay flop, preset to the idle-high bus level
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            rw        <= 1'b0;
            drive_low <= 1'b0;
            reg_addr  <= PTR_RESET;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            bit_cnt   <= nxt_bit_cnt;
            shift_reg <= nxt_shift;
            rw        <= nxt_rw;
            drive_low <= nxt_drive_low;
            reg_addr  <= nxt_addr;
            reg_wdata <= nxt_wdata;
            reg_we    <= nxt_we;
            busy      <= nxt_busy;
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling.
    // In the ACK states drive_low doubles as the "ACK in progress" flag; in
    // RDATA_ACK bit_cnt==1 marks that the master acknowledged.
    always_comb begin
        nxt_state     = cur_state;
        nxt_bit_cnt   = bit_cnt;
        nxt_shift     = shift_reg;
        nxt_rw        = rw;
        nxt_drive_low = drive_low;
        nxt_addr      = reg_addr;
        nxt_wdata     = reg_wdata;
        nxt_we        = 1'b0;
        nxt_busy      = busy;

        if (start_cond) begin
            nxt_state     = ADDR;
            nxt_bit_cnt   = 3'd0;
            nxt_drive_low = 1'b0;
        end else if (stop_cond) begin
            nxt_state     = IDLE;
            nxt_busy      = 1'b0;
            nxt_drive_low = 1'b0;
        end else begin
            case (cur_state)
                IDLE: begin
                    nxt_drive_low = 1'b0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        nxt_shift   = shift_in;
                        nxt_bit_cnt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            nxt_bit_cnt = 3'd0;
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                nxt_state = ADDR_ACK;
                                nxt_busy  = 1'b1;
                                nxt_rw    = shift_in[0];
                            end else begin
                                nxt_state = IGNORE;
                                nxt_busy  = 1'b0;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            nxt_drive_low = 1'b1;
                        end else begin
                            nxt_bit_cnt = 3'd0;
                            if (rw) begin
                                nxt_state     = RDATA;
                                nxt_shift     = reg_rdata;
                                nxt_drive_low = ~reg_rdata[7];
                            end else begin
                                nxt_state     = PTR;
                                nxt_drive_low = 1'b0;
                            end
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        nxt_shift   = shift_in;
                        nxt_bit_cnt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            nxt_bit_cnt = 3'd0;
                            nxt_addr    = shift_in;
                            nxt_state   = PTR_ACK;
                        end
                    end
                end

                PTR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            nxt_drive_low = 1'b1;
                        end else begin
                            nxt_drive_low = 1'b0;
                            nxt_bit_cnt   = 3'd0;
                            nxt_state     = WDATA;
                        end
                    end
                end

                WDATA: begin
                    if (scl_rise) begin
                        nxt_shift   = shift_in;
                        nxt_bit_cnt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            nxt_bit_cnt = 3'd0;
                            nxt_wdata   = shift_in;
                            nxt_we      = 1'b1;
                            nxt_state   = WDATA_ACK;
                        end
                    end
                end

                WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            nxt_drive_low = 1'b1;
                        end else begin
                            nxt_drive_low = 1'b0;
                            nxt_bit_cnt   = 3'd0;
                            nxt_addr      = reg_addr + 8'd1;
                            nxt_state     = WDATA;
                        end
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            nxt_bit_cnt   = 3'd0;
                            nxt_drive_low = 1'b0;
                            nxt_state     = RDATA_ACK;
                        end else begin
                            nxt_bit_cnt   = bit_cnt + 3'd1;
                            nxt_shift     = {shift_reg[6:0], 1'b0};
                            nxt_drive_low = ~shift_reg[6];
                        end
                    end
                end

                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            nxt_addr    = reg_addr + 8'd1;
                            nxt_bit_cnt = 3'd1;
                        end else begin
                            nxt_state = IGNORE;
                            nxt_busy  = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt == 3'd1) begin
                        nxt_bit_cnt   = 3'd0;
                        nxt_shift     = reg_rdata;
                        nxt_drive_low = ~reg_rdata[7];
                        nxt_state     = RDATA;
                    end
                end

                IGNORE: begin
                    nxt_drive_low = 1'b0;
                end

                default: begin
                    nxt_state     = IDLE;
                    nxt_drive_low = 1'b0;
                    nxt_busy      = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C master driving i2c_slave_regs, with a
// user register file behind the register port and a transaction-level model
// (pointer arithmetic, expected writes, expected read bytes).
module tb_i2c_slave_regs;

    localparam int Q = 10;
    localparam int H = 20;
    localparam logic [6:0] SLAVE = 7'h77;
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_IGNORE = 4'd9;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic [3:0] state;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  ref_ptr;
    logic [7:0]  wbuf [8];
    logic [15:0] wr_log [$];
    logic [15:0] exp_wr [$];

    int checks = 0;
    int errors = 0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    assign reg_rdata = mem[reg_addr];

    i2c_slave_regs dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .state     (state)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Record every clock cycle the write strobe is high
    always @(negedge clk) begin
        if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
    end

    // Guard against a hung run
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic busStart();
        m_low = 1'b0;
        tick(H);
        scl = 1'b1;
        tick(H);
        m_low = 1'b1;
        tick(H);
        scl = 1'b0;
        tick(H);
    endtask

    task automatic busStop();
        m_low = 1'b1;
        tick(H);
        scl = 1'b1;
        tick(H);
        m_low = 1'b0;
        tick(H);
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tick(Q);
            m_low = ~b[7-i];
            tick(Q);
            scl = 1'b1;
            tick(H);
            scl = 1'b0;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        sendBits(b, 8);
        tick(Q);
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        ack = (sda === 1'b0);
        tick(Q);
        scl = 1'b0;
    endtask

    task automatic recvByte(output logic [7:0] b, input logic nack);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            tick(Q);
            scl = 1'b1;
            tick(Q);
            b[i] = (sda === 1'b0) ? 1'b0 : 1'b1;
            tick(Q);
            scl = 1'b0;
        end
        tick(Q);
        m_low = ~nack;
        tick(Q);
        scl = 1'b1;
        tick(H);
        scl = 1'b0;
        tick(Q);
        m_low = 1'b0;
    endtask

    task automatic checkWrites(input string tag);
        int n;
        checkOutput({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < n; i++) checkOutput({tag, "_wr_addr_data"}, wr_log[i], exp_wr[i]);
        foreach (wr_log[i]) mem[wr_log[i][15:8]] = wr_log[i][7:0];
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic applyStimulusWrite(input logic [7:0] ptr, input int n);
        logic ack;
        busStart();
        sendByte({SLAVE, 1'b0}, ack);
        checkOutput("wr_addr_ack", ack, 1);
        checkOutput("wr_busy_high", busy, 1);
        sendByte(ptr, ack);
        checkOutput("wr_ptr_ack", ack, 1);
        ref_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            sendByte(wbuf[i], ack);
            checkOutput("wr_data_ack", ack, 1);
            exp_wr.push_back({ref_ptr, wbuf[i]});
            ref_mem[ref_ptr] = wbuf[i];
            ref_ptr = ref_ptr + 8'd1;
        end
        busStop();
        tick(4);
        checkOutput("wr_busy_after_stop", busy, 0);
        checkOutput("wr_state_idle", state, ST_IDLE);
        checkOutput("wr_reg_addr_end", reg_addr, ref_ptr);
        checkWrites("wr");
    endtask

    task automatic applyStimulusRead(input logic [7:0] ptr, input int n);
        logic       ack;
        logic [7:0] b;
        busStart();
        sendByte({SLAVE, 1'b0}, ack);
        checkOutput("rd_addr_ack", ack, 1);
        sendByte(ptr, ack);
        checkOutput("rd_ptr_ack", ack, 1);
        busStart();
        sendByte({SLAVE, 1'b1}, ack);
        checkOutput("rd_raddr_ack", ack, 1);
        checkOutput("rd_busy_high", busy, 1);
        ref_ptr = ptr;
        for (int i = 0; i < n; i++) begin
            recvByte(b, i == n - 1);
            checkOutput("rd_data", b, ref_mem[ref_ptr]);
            if (i != n - 1) ref_ptr = ref_ptr + 8'd1;
        end
        tick(4);
        checkOutput("rd_sda_released", sda, 1);
        checkOutput("rd_state_ignore", state, ST_IGNORE);
        checkOutput("rd_busy_after_nack", busy, 0);
        busStop();
        tick(4);
        checkOutput("rd_state_idle", state, ST_IDLE);
        checkOutput("rd_reg_addr_end", reg_addr, ref_ptr);
        checkWrites("rd");
    endtask

    task automatic applyStimulusMismatch(input logic [6:0] a7, input logic rw);
        logic ack;
        logic [7:0] ptr_before;
        ptr_before = ref_ptr;
        busStart();
        sendByte({a7, rw}, ack);
        checkOutput("mm_addr_noack", ack, 0);
        checkOutput("mm_busy_low", busy, 0);
        checkOutput("mm_state_ignore", state, ST_IGNORE);
        sendByte(8'h12, ack);
        checkOutput("mm_data_noack", ack, 0);
        busStop();
        tick(4);
        checkOutput("mm_state_idle", state, ST_IDLE);
        checkOutput("mm_reg_addr", reg_addr, ptr_before);
        checkWrites("mm");
    endtask

    initial begin
        int         kind;
        int         n;
        logic       ack;
        logic [6:0] a7;

        reset = 1'b1;
        scl   = 1'b1;
        m_low = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = ~i[7:0];
            ref_mem[i] = ~i[7:0];
        end
        ref_ptr = 8'h00;
        tick(3);
        reset = 1'b0;
        tick(3);
        $display("[TB] reset state");
        checkOutput("rst_reg_addr", reg_addr, 8'h00);
        checkOutput("rst_reg_wdata", reg_wdata, 8'h00);
        checkOutput("rst_reg_we", reg_we, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_state", state, ST_IDLE);
        checkOutput("rst_sda", sda, 1);

        $display("[TB] pointer write 0xF4 <- 0x2E");
        wbuf[0] = 8'h2E;
        applyStimulusWrite(8'hF4, 1);

        $display("[TB] ID read via repeated START");
        mem[8'hD0]     = 8'h55;
        ref_mem[8'hD0] = 8'h55;
        applyStimulusRead(8'hD0, 1);

        $display("[TB] burst read with pointer wrap");
        applyStimulusRead(8'hFE, 3);

        $display("[TB] address mismatch");
        applyStimulusMismatch(7'h50, 1'b0);

        $display("[TB] reset in the middle of a data byte");
        busStart();
        sendByte({SLAVE, 1'b0}, ack);
        checkOutput("rstmid_addr_ack", ack, 1);
        sendByte(8'h30, ack);
        checkOutput("rstmid_ptr_ack", ack, 1);
        sendBits(8'h5A, 4);
        m_low = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        checkOutput("rstmid_sda", sda, 1);
        checkOutput("rstmid_state", state, ST_IDLE);
        checkOutput("rstmid_reg_addr", reg_addr, 8'h00);
        checkOutput("rstmid_busy", busy, 0);
        ref_ptr = 8'h00;
        checkWrites("rstmid");
        wbuf[0] = 8'hC3;
        wbuf[1] = 8'h3C;
        applyStimulusWrite(8'h40, 2);

        $display("[TB] START aborts a partial data byte");
        busStart();
        sendByte({SLAVE, 1'b0}, ack);
        checkOutput("abort_addr_ack", ack, 1);
        sendByte(8'h20, ack);
        checkOutput("abort_ptr_ack", ack, 1);
        sendBits(8'hA5, 5);
        busStart();
        sendByte({SLAVE, 1'b0}, ack);
        checkOutput("abort_addr2_ack", ack, 1);
        sendByte(8'h10, ack);
        checkOutput("abort_ptr2_ack", ack, 1);
        sendByte(8'h99, ack);
        checkOutput("abort_data_ack", ack, 1);
        busStop();
        tick(4);
        exp_wr.push_back({8'h10, 8'h99});
        ref_mem[8'h10] = 8'h99;
        ref_ptr = 8'h11;
        checkOutput("abort_reg_addr", reg_addr, ref_ptr);
        checkWrites("abort");

        $display("[TB] randomized transactions");
        for (int t = 0; t < 10; t++) begin
            kind = int'($urandom_range(0, 2));
            case (kind)
                0: begin
                    n = int'($urandom_range(0, 4));
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    applyStimulusWrite(8'($urandom), n);
                end
                1: begin
                    applyStimulusRead(8'($urandom), int'($urandom_range(1, 4)));
                end
                default: begin
                    a7 = 7'($urandom);
                    if (a7 == SLAVE) a7 = a7 ^ 7'h01;
                    applyStimulusMismatch(a7, 1'($urandom));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C responder (target) block: the far end of the existing master, at one 7-bit bus address.
- Decodes START, STOP and repeated START on scl/sda, matches the address, ACKs, and maintains an 8-bit register pointer.
- Write bytes go to a user register port; read bytes are fetched from that port and shifted out.
- Used as an on-board BMP180 stand-in and as the bench responder for the master/BMP180 controller.

Parameters:
SLAVE_ADDR, 7'h77, 7-bit bus address this block answers to
PTR_RESET, 8'h00, pointer value after reset

Ports:
clk  input  1  system clock (must be at least 16x the scl rate)
reset  input  1  synchronous, active-high reset
scl  input  1  I2C clock; sampled only, never driven
sda  inout  8'h1  I2C data; open-drain: driven 0 or released to 'z', never driven 1
reg_addr  output  8  current register pointer
reg_wdata  output  8  byte received for a register write
reg_we  output  1  one-clk write strobe; reg_wdata is written to reg_addr
reg_rdata  input  8  read data for reg_addr; user presents it within 1 clk of reg_addr changing
busy  output  1  high from an address-matched START until STOP, NACK-end or mismatch
state  output  4  current FSM state encoding, for debug LEDs

Behaviour:
- Clock and reset:
  - Single clock, clk. reset is synchronous and active-high.
- Reset values:
  - reg_addr=PTR_RESET, reg_wdata=0, reg_we=0, busy=0, state=IDLE.
  - sda released.
  - Synchronizers are preset to 1.
- Synchronisation:
  - scl and sda each pass through 2 flops, plus one delay flop for edge detection.
  - All decisions use the synchronized values, giving 3-clk input latency.
- Bus condition detection:
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Both are detected in every state and take priority over bit processing in the same clk.
- Bit timing:
  - Input bits are sampled on the synchronized scl rising edge, MSB first.
  - The block changes its sda drive only on the synchronized scl falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- State transitions:
  - Any state, on START: go to ADDR, clear the bit counter, release sda. The pointer is kept, so repeated START works for reads.
  - Any state, on STOP: go to IDLE, busy=0, release sda.
  - ADDR: shift in 8 bits.
    - If bits[7:1]==SLAVE_ADDR: go to ADDR_ACK, busy=1, latch rw=bit0.
    - Otherwise: go to IGNORE.
  - ADDR_ACK:
    - Pull sda low from the falling edge after bit 8 until the next falling edge.
    - Then go to PTR if rw=0.
    - If rw=1: go to RDATA, load the shift register from reg_rdata, drive its MSB.
  - PTR: shift 8 bits, then go to PTR_ACK with reg_addr set to that byte. ACK as in ADDR_ACK, then go to WDATA.
  - WDATA:
    - Shift 8 bits. On the 8th sampled bit: reg_wdata=byte, reg_we=1 for exactly 1 clk, go to WDATA_ACK.
    - After the ACK: reg_addr = reg_addr+1, wrapping 8'hFF to 8'h00.
  - RDATA: drive 8 bits, changing sda on falling edges. After the 8th falling edge, release sda and go to RDATA_ACK.
  - RDATA_ACK: sample the master's bit on the rising edge.
    - ACK (0): reg_addr+1 with wrap; on the falling edge reload from reg_rdata and go to RDATA.
    - NACK (1): go to IGNORE, busy=0.
  - IGNORE: sda stays released; wait for START or STOP.
- ACK policy:
  - Matched address, pointer and write bytes are always ACKed.
  - A mismatched address is never ACKed.
- Repeated START:
  - A write to the pointer followed by START and a read address returns data from that pointer.
- Reset mid-transfer:
  - Takes effect on the next clk: sda released, FSM to IDLE, pointer to PTR_RESET.
  - The block then ignores the bus until the next START.
- Glitch tolerance:
  - A START or STOP inside a byte aborts that byte. No reg_we is issued for a partial byte.
- sda drive: sda = drive_low ? 1'b0 : 1'bz.

Test Plan:
- Write pointer: START, 0xEE, 0xF4, 0x2E, STOP → ACK after each byte; one reg_we pulse with reg_addr=0xF4, reg_wdata=0x2E; reg_addr=0xF5 at the end; busy falls at STOP.
- ID read via repeated START: START, 0xEE, 0xD0, START, 0xEF, read 1 byte and NACK, STOP; user returns 0x55 at 0xD0 → master receives 0x55, sda released after the NACK, state=IGNORE then IDLE.
- Burst read with wrap: pointer 0xFE, read 3 bytes with ACK, ACK, NACK; reg_rdata=~reg_addr → bytes 0x01, 0x00, 0xFF; reg_addr ends at 0x00.
- Address mismatch: START, 0xA0, 0x12, STOP → no ACK (sda high on the 9th clock), no reg_we, busy stays 0.
- Reset mid-byte: assert reset for 1 clk after 4 bits of a write data byte → sda released, state=IDLE, reg_addr=0x00, no reg_we; the next valid transaction works normally.
- Abort by START: START after 5 bits of WDATA, then a full write of 0xEE, 0x10, 0x99 → only one reg_we (addr 0x10, data 0x99).
